// File: rtl/aes_pkg.sv
// Shared AES types and GF(2^8) helpers for the round datapath.
// Column mixer state machine encoding lives here as well.
package aes_pkg;

   typedef logic [3:0][3:0][7:0] block_t;

   typedef enum logic [1:0] {
      IDLE,
      MIX,
      DONE
   } mix_state_t;

   localparam logic [7:0] AES_REDUCE = 8'h1b;

   function automatic logic [7:0] xtime(input logic [7:0] b);
      return {b[6:0], 1'b0} ^ (AES_REDUCE & {8{b[7]}});
   endfunction

   function automatic logic [7:0] gf_mul2(input logic [7:0] b);
      return xtime(b);
   endfunction

   function automatic logic [7:0] gf_mul3(input logic [7:0] b);
      return xtime(b) ^ b;
   endfunction

   // Inverse coefficients decompose into x8/x4/x2/x1 partial products.
   function automatic logic [7:0] gf_mul9(input logic [7:0] b);
      logic [7:0] x8;
      x8 = xtime(xtime(xtime(b)));
      return x8 ^ b;
   endfunction

   function automatic logic [7:0] gf_mul11(input logic [7:0] b);
      logic [7:0] x2;
      logic [7:0] x8;
      x2 = xtime(b);
      x8 = xtime(xtime(x2));
      return x8 ^ x2 ^ b;
   endfunction

   function automatic logic [7:0] gf_mul13(input logic [7:0] b);
      logic [7:0] x4;
      logic [7:0] x8;
      x4 = xtime(xtime(b));
      x8 = xtime(x4);
      return x8 ^ x4 ^ b;
   endfunction

   function automatic logic [7:0] gf_mul14(input logic [7:0] b);
      logic [7:0] x2;
      logic [7:0] x4;
      logic [7:0] x8;
      x2 = xtime(b);
      x4 = xtime(x2);
      x8 = xtime(x4);
      return x8 ^ x4 ^ x2;
   endfunction

endpackage

// File: rtl/mix_single_col.sv
// Combinational MixColumns / InvMixColumns of one 4-byte column.
// Byte 0 of col is row 0.
module mix_single_col
   import aes_pkg::*;
(
   input  logic [3:0][7:0] col,
   input  logic            inverse,
   output logic [3:0][7:0] mixed
);

   for (genvar r = 0; r < 4; r++) begin : g_row
      logic [7:0] fwd;
      logic [7:0] inv;

      assign fwd = gf_mul2(col[r])
                 ^ gf_mul3(col[(r + 1) % 4])
                 ^ col[(r + 2) % 4]
                 ^ col[(r + 3) % 4];

      assign inv = gf_mul14(col[r])
                 ^ gf_mul11(col[(r + 1) % 4])
                 ^ gf_mul13(col[(r + 2) % 4])
                 ^ gf_mul9(col[(r + 3) % 4]);

      assign mixed[r] = inverse ? inv : fwd;
   end

endmodule

// File: rtl/mix_cols_engine.sv
// Multi-pass AES column mixer with run-time direction select.
// Mixes COLS_PER_CYCLE columns per clock, ready/start handshake.
module mix_cols_engine
   import aes_pkg::*;
#(
   parameter int COLS_PER_CYCLE = 1
)
(
   input  logic         clk_in,
   input  logic         rst_in,
   input  logic         start,
   input  logic         inverse_in,
   input  logic [127:0] block_in,
   output logic         ready_out,
   output logic [127:0] result_out,
   output logic         valid_out
);

   localparam int PASSES = 4 / COLS_PER_CYCLE;
   localparam int PW = (PASSES > 1) ? $clog2(PASSES) : 1;

   if (COLS_PER_CYCLE != 1 && COLS_PER_CYCLE != 2 &&
       COLS_PER_CYCLE != 4) begin : g_bad_cfg
      $error("COLS_PER_CYCLE must be 1, 2 or 4");
   end

   mix_state_t      state;
   mix_state_t      state_nxt;
   logic [PW-1:0]   pass_cnt;
   block_t          blk_q;
   logic            inv_q;
   block_t          work_q;
   block_t          work_nxt;
   logic            idle_or_done;
   logic            accept;
   logic            last_pass;

   logic [1:0]      col_idx [COLS_PER_CYCLE];
   logic [3:0][7:0] cols_src [COLS_PER_CYCLE];
   logic [3:0][7:0] cols_mix [COLS_PER_CYCLE];

   assign idle_or_done = (state == IDLE) || (state == DONE);
   assign ready_out    = !rst_in && idle_or_done;
   assign accept       = start && idle_or_done;
   assign last_pass    = (pass_cnt == PW'(PASSES - 1));
   assign valid_out    = (state == DONE);

   always_comb begin
      for (int i = 0; i < COLS_PER_CYCLE; i++) begin
         col_idx[i] = 2'(int'(pass_cnt) * COLS_PER_CYCLE + i);
         for (int r = 0; r < 4; r++) begin
            cols_src[i][r] = blk_q[r][col_idx[i]];
         end
      end
   end

   for (genvar i = 0; i < COLS_PER_CYCLE; i++) begin : g_col
      mix_single_col u_col (
         .col     (cols_src[i]),
         .inverse (inv_q),
         .mixed   (cols_mix[i])
      );
   end

   // Only this pass's columns change; earlier passes are kept.
   always_comb begin
      work_nxt = work_q;
      for (int i = 0; i < COLS_PER_CYCLE; i++) begin
         for (int r = 0; r < 4; r++) begin
            work_nxt[r][col_idx[i]] = cols_mix[i][r];
         end
      end
   end

   always_comb begin
      state_nxt = state;
      unique case (state)
         IDLE:    if (start) state_nxt = MIX;
         MIX:     if (last_pass) state_nxt = DONE;
         DONE:    state_nxt = start ? MIX : IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         state      <= IDLE;
         pass_cnt   <= '0;
         result_out <= '0;
      end else begin
         state <= state_nxt;
         if (accept) begin
            blk_q    <= block_in;
            inv_q    <= inverse_in;
            pass_cnt <= '0;
         end else if (state == MIX) begin
            work_q <= work_nxt;
            if (last_pass) begin
               result_out <= work_nxt;
            end else begin
               pass_cnt <= pass_cnt + PW'(1);
            end
         end
      end
   end

endmodule

// File: tb/tb_mix_cols_engine.sv
// Scoreboard bench: three engines (1/2/4 columns per cycle) on
// shared data inputs, each with its own start and expectation queue.
module tb_mix_cols_engine;

   typedef struct {
      logic [127:0] res;
      int           cyc;
   } exp_t;

   localparam logic [127:0] V1 = 128'h45454545_53535353_13131313_dbdbdbdb;
   localparam logic [127:0] R1 = 128'hbcbcbcbc_a1a1a1a1_4d4d4d4d_8e8e8e8e;
   localparam logic [127:0] VM = 128'hc6015c45_c6012253_c6010a13_c601f2db;
   localparam logic [127:0] RM = 128'hc6019dbc_c60158a1_c601dc4d_c6019f8e;
   localparam logic [127:0] VF = 128'he5f1ae30_9811525d_2741b4bf_1eb8e0d4;
   localparam logic [127:0] RF = 128'h4c7a9ae5_26d31981_06f8cb66_2848e004;
   localparam logic [127:0] V01 = {16{8'h01}};

   logic         clk = 1'b0;
   logic         rst;
   logic [2:0]   start;
   logic         inv;
   logic [127:0] blk;
   logic [2:0]   ready;
   logic [2:0]   valid;
   logic [127:0] res0;
   logic [127:0] res1;
   logic [127:0] res2;
   logic [2:0]   pv = '0;
   int           cyc = 0;
   int           errors = 0;
   int           checks = 0;
   exp_t         q0[$];
   exp_t         q1[$];
   exp_t         q2[$];

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   mix_cols_engine #(.COLS_PER_CYCLE(1)) u_c1 (
      .clk_in(clk), .rst_in(rst), .start(start[0]),
      .inverse_in(inv), .block_in(blk), .ready_out(ready[0]),
      .result_out(res0), .valid_out(valid[0])
   );

   mix_cols_engine #(.COLS_PER_CYCLE(2)) u_c2 (
      .clk_in(clk), .rst_in(rst), .start(start[1]),
      .inverse_in(inv), .block_in(blk), .ready_out(ready[1]),
      .result_out(res1), .valid_out(valid[1])
   );

   mix_cols_engine #(.COLS_PER_CYCLE(4)) u_c4 (
      .clk_in(clk), .rst_in(rst), .start(start[2]),
      .inverse_in(inv), .block_in(blk), .ready_out(ready[2]),
      .result_out(res2), .valid_out(valid[2])
   );

   function automatic int passes(input int k);
      return (k == 0) ? 4 : (k == 1) ? 2 : 1;
   endfunction

   function automatic logic [127:0] get_res(input int k);
      return (k == 0) ? res0 : (k == 1) ? res1 : res2;
   endfunction

   function automatic int qsize();
      return q0.size() + q1.size() + q2.size();
   endfunction

   task automatic check(input string name, input logic [127:0] act,
                        input logic [127:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic push(input int k, input exp_t e);
      case (k)
         0:       q0.push_back(e);
         1:       q1.push_back(e);
         default: q2.push_back(e);
      endcase
   endtask

   task automatic monitor(input int k, input logic v, input logic [127:0] r);
      exp_t e;
      int   n;
      if (v) begin
         n = (k == 0) ? q0.size() : (k == 1) ? q1.size() : q2.size();
         checks++;
         if (pv[k]) begin
            errors++;
            $display("FAIL valid_twice dut%0d: got 2 cycles expected 1", k);
         end
         if (n == 0) begin
            checks++;
            errors++;
            $display("FAIL spurious_valid dut%0d: got valid expected none", k);
         end else begin
            case (k)
               0:       e = q0.pop_front();
               1:       e = q1.pop_front();
               default: e = q2.pop_front();
            endcase
            check($sformatf("result dut%0d", k), r, e.res);
            check($sformatf("valid_cycle dut%0d", k), 128'(cyc), 128'(e.cyc));
         end
      end
   endtask

   always @(negedge clk) begin
      monitor(0, valid[0], res0);
      monitor(1, valid[1], res1);
      monitor(2, valid[2], res2);
      pv <= valid;
   end

   task automatic scramble();
      blk = {$urandom, $urandom, $urandom, $urandom};
      inv = 1'($urandom);
   endtask

   // Offer a block when dut k is ready; expectation queued at acceptance.
   task automatic send(input int k, input logic [127:0] b, input logic i,
                       input logic [127:0] e, input bit keep,
                       input bit noisy, input int want_wait, input bit expect_out);
      int   w;
      exp_t x;
      w = 0;
      do begin
         @(negedge clk);
         w++;
         if (!ready[k] && noisy) scramble();
      end while (!ready[k] && w < 50);
      if (!ready[k]) begin
         checks++;
         errors++;
         $display("FAIL ready_timeout dut%0d: got ready=0 expected 1", k);
         return;
      end
      if (want_wait > 0)
         check($sformatf("accept_spacing dut%0d", k), 128'(w), 128'(want_wait));
      blk = b;
      inv = i;
      start[k] = 1'b1;
      @(posedge clk);
      #1;
      x.res = e;
      x.cyc = cyc + passes(k);
      if (expect_out) push(k, x);
      start[k] = keep;
      if (noisy) scramble();
   endtask

   initial begin
      int p;
      rst = 1'b1;
      start = '0;
      inv = 1'b0;
      blk = '0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      check("reset_ready", 128'(ready), 128'(0));
      check("reset_valid", 128'(valid), 128'(0));
      check("reset_res0", res0, 128'(0));
      check("reset_res1", res1, 128'(0));
      check("reset_res2", res2, 128'(0));
      rst = 1'b0;
      @(negedge clk);
      check("ready_after_reset", 128'(ready), 128'(3'b111));

      for (int k = 0; k < 3; k++) begin
         p = passes(k);
         send(k, V1, 1'b0, R1, 1'b0, 1'b0, -1, 1'b1);
         send(k, R1, 1'b1, V1, 1'b0, 1'b0, -1, 1'b1);
         send(k, VM, 1'b0, RM, 1'b0, 1'b0, -1, 1'b1);
         send(k, RM, 1'b1, VM, 1'b0, 1'b0, -1, 1'b1);
         send(k, VF, 1'b0, RF, 1'b1, 1'b1, -1, 1'b1);
         send(k, RF, 1'b1, VF, 1'b1, 1'b1, p + 1, 1'b1);
         send(k, VM, 1'b0, RM, 1'b1, 1'b1, p + 1, 1'b1);
         send(k, RM, 1'b1, VM, 1'b0, 1'b1, p + 1, 1'b1);
      end

      send(0, '0, 1'b0, '0, 1'b0, 1'b0, -1, 1'b1);
      send(0, V01, 1'b1, V01, 1'b0, 1'b0, -1, 1'b1);
      send(0, V1, 1'b0, R1, 1'b0, 1'b0, -1, 1'b1);
      for (int t = 0; t < 100 && qsize() != 0; t++) @(negedge clk);
      check("drain_before_reset", 128'(qsize()), 128'(0));

      send(0, VF, 1'b0, RF, 1'b0, 1'b0, -1, 1'b0);
      @(posedge clk);
      #1;
      rst = 1'b1;
      @(posedge clk);
      #1;
      check("midmix_valid", 128'(valid[0]), 128'(0));
      check("midmix_ready_in_reset", 128'(ready[0]), 128'(0));
      check("midmix_result", res0, 128'(0));
      rst = 1'b0;
      @(negedge clk);
      check("midmix_ready_after", 128'(ready[0]), 128'(1));

      rst = 1'b1;
      blk = V1;
      inv = 1'b0;
      start[0] = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      start[0] = 1'b0;
      @(negedge clk);
      check("start_during_reset_ready", 128'(ready[0]), 128'(1));
      repeat (6) @(negedge clk);
      check("start_during_reset_res", res0, 128'(0));

      send(0, VM, 1'b0, RM, 1'b0, 1'b0, -1, 1'b1);
      send(2, RF, 1'b1, VF, 1'b0, 1'b0, -1, 1'b1);

      for (int t = 0; t < 100 && qsize() != 0; t++) @(negedge clk);
      check("final_drain", 128'(qsize()), 128'(0));
      repeat (3) @(negedge clk);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
